result_collector: RTL and testbench

- Receiving end of the matrix-multiply result stream.
- The multiply controller serialises each result element as CHUNKS consecutive chunks. This block reassembles the chunks into full-width words and stores them in an internal result buffer.
- It then exposes the buffer through a synchronous read port, with completion and overflow status.
- It sits between the multiplier datapath output and the host/readback logic.

---
 rtl/matmul_pkg.sv | 14 +
 rtl/result_collector_if.sv | 25 ++
 rtl/result_buf.sv | 33 +++
 rtl/result_collector.sv | 93 +++++++++
 tb/tb_result_collector.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/matmul_pkg.sv
// Shared constants and the sequencing state encoding for the matrix-multiply result path.
package matmul_pkg;
  localparam int CW     = 8;
  localparam int CHUNKS = 3;
  localparam int NE     = 9;
  localparam int AW     = 8;
  localparam int W      = CW * CHUNKS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } state_t;
endpackage

// File: rtl/result_collector_if.sv
// Chunk input, buffer read port and status of the result collector.
interface result_collector_if;
  import matmul_pkg::*;

  logic          start;
  logic          in_valid;
  logic [CW-1:0] in_chunk;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic          word_valid;
  logic [AW-1:0] elem_count;
  logic          busy;
  logic          complete;
  logic          overflow;

  modport master (
    output start, in_valid, in_chunk, rd_addr,
    input  rd_data, word_valid, elem_count, busy, complete, overflow
  );

  modport slave (
    input  start, in_valid, in_chunk, rd_addr,
    output rd_data, word_valid, elem_count, busy, complete, overflow
  );
endinterface

// File: rtl/result_buf.sv
// NE x W result storage: one write port, one registered read port; out-of-range reads return 0.
module result_buf
  import matmul_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);
  localparam int IW = $clog2(NE);

  logic [W-1:0] mem [NE];

  // Storage is never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we && (wr_addr < AW'(NE))) begin
      mem[wr_addr[IW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_addr < AW'(NE)) begin
      rd_data <= mem[rd_addr[IW-1:0]];
    end else begin
      rd_data <= '0;
    end
  end
endmodule

// File: rtl/result_collector.sv
// Reassembles CHUNKS-wide serialised result elements into words and stores NE of them for readback.
module result_collector
  import matmul_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  result_collector_if.slave  bus
);
  localparam int CCW = $clog2(CHUNKS + 1);
  localparam logic [CCW-1:0] LAST_CHUNK = CCW'(CHUNKS - 1);

  state_t            state, state_nxt;
  logic [W-CW-1:0]   asm_q, asm_nxt;
  logic [CCW-1:0]    chunk_cnt, chunk_nxt;
  logic [AW-1:0]     elem_q, elem_nxt;
  logic              ovf_q, ovf_nxt;
  logic              wv_q, wv_nxt;
  logic              wr_en;
  logic [W-1:0]      word;

  assign word = {asm_q, bus.in_chunk};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      asm_q     <= '0;
      chunk_cnt <= '0;
      elem_q    <= '0;
      ovf_q     <= 1'b0;
      wv_q      <= 1'b0;
    end else begin
      state     <= state_nxt;
      asm_q     <= asm_nxt;
      chunk_cnt <= chunk_nxt;
      elem_q    <= elem_nxt;
      ovf_q     <= ovf_nxt;
      wv_q      <= wv_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    asm_nxt   = asm_q;
    chunk_nxt = chunk_cnt;
    elem_nxt  = elem_q;
    ovf_nxt   = ovf_q;
    wv_nxt    = 1'b0;
    wr_en     = 1'b0;

    // start takes priority in every state; a coincident chunk is dropped.
    if (bus.start) begin
      state_nxt = COLLECT;
      asm_nxt   = '0;
      chunk_nxt = '0;
      elem_nxt  = '0;
      ovf_nxt   = 1'b0;
    end else if (bus.in_valid) begin
      case (state)
        COLLECT: begin
          asm_nxt = word[W-CW-1:0];
          if (chunk_cnt == LAST_CHUNK) begin
            wr_en     = 1'b1;
            wv_nxt    = 1'b1;
            chunk_nxt = '0;
            elem_nxt  = elem_q + AW'(1);
            if (elem_q + AW'(1) == AW'(NE)) begin
              state_nxt = FULL;
            end
          end else begin
            chunk_nxt = chunk_cnt + CCW'(1);
          end
        end
        default: ovf_nxt = 1'b1;
      endcase
    end
  end

  result_buf u_buf (
    .clk     (clk),
    .rst     (rst),
    .we      (wr_en && !rst),
    .wr_addr (elem_q),
    .wr_data (word),
    .rd_addr (bus.rd_addr),
    .rd_data (bus.rd_data)
  );

  assign bus.word_valid = wv_q;
  assign bus.elem_count = elem_q;
  assign bus.busy       = (state == COLLECT);
  assign bus.complete   = (state == FULL);
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_result_collector.sv
// Directed scenario bench for result_collector with hand-computed expected values.
module tb_result_collector;
  import matmul_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vec  = 0;
  int   errs = 0;
  int   wv_count;

  result_collector_if dif();

  result_collector dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_chunk(input logic [7:0] c);
    dif.in_valid = 1'b1;
    dif.in_chunk = c;
    tick();
    dif.in_valid = 1'b0;
    if (dif.word_valid === 1'b1) wv_count++;
  endtask

  task automatic do_start();
    dif.start = 1'b1;
    tick();
    dif.start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [23:0] d);
    dif.rd_addr = a;
    tick();
    d = dif.rd_data;
  endtask

  task automatic test_reset();
    logic [29:0] obs;
    do_reset();
    obs = {dif.rd_data, dif.word_valid, dif.elem_count[2:0], dif.busy, dif.complete};
    vec++;
    if (obs !== 30'h0 || dif.overflow !== 1'b0 || dif.elem_count !== 8'd0) begin
      errs++; $display("FAIL reset_outputs: got %h ovf=%b cnt=%0d, want all 0", obs, dif.overflow, dif.elem_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] d;
    do_start();
    wv_count = 0;
    for (int i = 1; i <= 27; i++) send_chunk(8'(i));
    vec++;
    if (wv_count !== 9) begin errs++; $display("FAIL b2b_word_valid_pulses: got %0d want 9", wv_count); end
    vec++;
    if (dif.complete !== 1'b1 || dif.busy !== 1'b0) begin
      errs++; $display("FAIL b2b_complete: complete=%b busy=%b want 1 0", dif.complete, dif.busy);
    end
    vec++;
    if (dif.elem_count !== 8'd9) begin errs++; $display("FAIL b2b_elem_count: got %0d want 9", dif.elem_count); end
    vec++;
    if (dif.overflow !== 1'b0) begin errs++; $display("FAIL b2b_overflow: got %b want 0", dif.overflow); end
    rd(8'd0, d);
    vec++;
    if (d !== 24'h010203) begin errs++; $display("FAIL b2b_buf0: got %h want 010203", d); end
    rd(8'd8, d);
    vec++;
    if (d !== 24'h191A1B) begin errs++; $display("FAIL b2b_buf8: got %h want 191a1b", d); end
  endtask

  task automatic test_gaps();
    logic [23:0] d;
    logic        busy_ok;
    logic [7:0]  c;
    busy_ok = 1'b1;
    do_start();
    for (int i = 0; i < 27; i++) begin
      c = (i == 0) ? 8'h00 : (i == 1) ? 8'h12 : (i == 2) ? 8'h34 : 8'(i);
      send_chunk(c);
      if (i < 26) begin
        if (dif.busy !== 1'b1) busy_ok = 1'b0;
        for (int g = 0; g < 2; g++) begin
          tick();
          if (dif.busy !== 1'b1) busy_ok = 1'b0;
        end
      end
    end
    vec++;
    if (busy_ok !== 1'b1) begin errs++; $display("FAIL gaps_busy_held: got %b want 1", busy_ok); end
    vec++;
    if (dif.busy !== 1'b0 || dif.complete !== 1'b1) begin
      errs++; $display("FAIL gaps_done: busy=%b complete=%b want 0 1", dif.busy, dif.complete);
    end
    rd(8'd0, d);
    vec++;
    if (d !== 24'h001234) begin errs++; $display("FAIL gaps_buf0: got %h want 001234", d); end
  endtask

  task automatic test_overflow();
    logic [23:0] d;
    send_chunk(8'hFF);
    vec++;
    if (dif.overflow !== 1'b1) begin errs++; $display("FAIL ovf_set: got %b want 1", dif.overflow); end
    vec++;
    if (dif.elem_count !== 8'd9) begin errs++; $display("FAIL ovf_elem_count: got %0d want 9", dif.elem_count); end
    rd(8'd8, d);
    vec++;
    if (d !== 24'h18191A) begin errs++; $display("FAIL ovf_buf8: got %h want 18191a", d); end
    do_start();
    vec++;
    if (dif.overflow !== 1'b0 || dif.complete !== 1'b0 || dif.busy !== 1'b1 || dif.elem_count !== 8'd0) begin
      errs++; $display("FAIL ovf_restart: ovf=%b complete=%b busy=%b cnt=%0d want 0 0 1 0",
                       dif.overflow, dif.complete, dif.busy, dif.elem_count);
    end
  endtask

  task automatic test_restart();
    logic [23:0] d;
    for (int i = 0; i < 4; i++) send_chunk(8'(8'h11 + i));
    vec++;
    if (dif.elem_count !== 8'd1) begin errs++; $display("FAIL restart_partial_count: got %0d want 1", dif.elem_count); end
    do_start();
    for (int i = 0; i < 27; i++) send_chunk(8'(8'h40 + i));
    vec++;
    if (dif.elem_count !== 8'd9) begin errs++; $display("FAIL restart_elem_count: got %0d want 9", dif.elem_count); end
    rd(8'd0, d);
    vec++;
    if (d !== 24'h404142) begin errs++; $display("FAIL restart_buf0: got %h want 404142", d); end
    rd(8'd1, d);
    vec++;
    if (d !== 24'h434445) begin errs++; $display("FAIL restart_buf1: got %h want 434445", d); end
  endtask

  task automatic test_start_collision();
    logic [23:0] d;
    dif.start    = 1'b1;
    dif.in_valid = 1'b1;
    dif.in_chunk = 8'hAA;
    tick();
    dif.start    = 1'b0;
    dif.in_valid = 1'b0;
    send_chunk(8'h01);
    send_chunk(8'h02);
    send_chunk(8'h03);
    vec++;
    if (dif.elem_count !== 8'd1 || dif.overflow !== 1'b0) begin
      errs++; $display("FAIL collide_status: cnt=%0d ovf=%b want 1 0", dif.elem_count, dif.overflow);
    end
    rd(8'd0, d);
    vec++;
    if (d !== 24'h010203) begin errs++; $display("FAIL collide_buf0: got %h want 010203", d); end
  endtask

  task automatic test_read();
    logic [23:0] d;
    logic [23:0] exp;
    do_reset();
    do_start();
    for (int i = 1; i <= 27; i++) send_chunk(8'(i));
    for (int a = 0; a <= 9; a++) begin
      exp = (a < 9) ? {8'(3*a+1), 8'(3*a+2), 8'(3*a+3)} : 24'h0;
      rd(8'(a), d);
      vec++;
      if (d !== exp) begin errs++; $display("FAIL read_addr%0d: got %h want %h", a, d, exp); end
    end
    do_start();
    send_chunk(8'h0A);
    send_chunk(8'h0B);
    dif.rd_addr = 8'd0;
    send_chunk(8'h0C);
    vec++;
    if (dif.rd_data !== 24'h010203) begin errs++; $display("FAIL read_during_write: got %h want 010203", dif.rd_data); end
    rd(8'd0, d);
    vec++;
    if (d !== 24'h0A0B0C) begin errs++; $display("FAIL read_after_write: got %h want 0a0b0c", d); end
  endtask

  task automatic test_reset_mid();
    logic [23:0] d;
    do_start();
    for (int i = 0; i < 4; i++) send_chunk(8'(8'h21 + i));
    dif.rd_addr = 8'd0;
    do_reset();
    vec++;
    if (dif.rd_data !== 24'h0 || dif.word_valid !== 1'b0 || dif.elem_count !== 8'd0 ||
        dif.busy !== 1'b0 || dif.complete !== 1'b0 || dif.overflow !== 1'b0) begin
      errs++; $display("FAIL midreset_outputs: rd=%h wv=%b cnt=%0d busy=%b cpl=%b ovf=%b want all 0",
                       dif.rd_data, dif.word_valid, dif.elem_count, dif.busy, dif.complete, dif.overflow);
    end
    send_chunk(8'h55);
    vec++;
    if (dif.overflow !== 1'b1 || dif.busy !== 1'b0) begin
      errs++; $display("FAIL midreset_idle: ovf=%b busy=%b want 1 0", dif.overflow, dif.busy);
    end
    do_start();
    send_chunk(8'h31);
    send_chunk(8'h32);
    send_chunk(8'h33);
    rd(8'd0, d);
    vec++;
    if (d !== 24'h313233 || dif.elem_count !== 8'd1) begin
      errs++; $display("FAIL midreset_no_stale: buf0=%h cnt=%0d want 313233 1", d, dif.elem_count);
    end
  endtask

  initial begin
    dif.start    = 1'b0;
    dif.in_valid = 1'b0;
    dif.in_chunk = 8'h00;
    dif.rd_addr  = 8'h00;
    wv_count     = 0;
    test_reset();
    test_back_to_back();
    test_gaps();
    test_overflow();
    test_restart();
    test_start_collision();
    test_read();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
